// File: rtl/int_scheduler.sv
// Two-source interrupt scheduler for an 8080-style CPU. It latches request edges and raises iint.
// Latency: edge to pending is 1 cycle (3 with the synchronizer), pending to iint is 1 cycle, and the data drive is combinational.
// Backpressure: requests keep latching while masked or unserved; a repeat edge on a pending source sets overrun.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   irq_a, irq_b        request levels (A = mid-screen, B = vblank); rising edges are the events
//   int_en              iint mask (requests still latch while masked)
//   inta, dbin          CPU acknowledge status bit and data-in strobe
//   clr_overrun         clears both overrun flags
//   data                RST opcode driven during acknowledge, high-Z otherwise
//   iint                registered interrupt request to the CPU
//   pending, overrun    [0] = source A, [1] = source B
//
// Build option: define INT_SCHEDULER_SYNC_EN to pass irq_a/irq_b through a
// two-flop synchronizer before edge detection.
module int_scheduler #(
  parameter int         XLEN  = 8,
  parameter logic [2:0] VEC_A = 3'b001,
  parameter logic [2:0] VEC_B = 3'b010
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            irq_a,
  input  logic            irq_b,
  input  logic            int_en,
  input  logic            inta,
  input  logic            dbin,
  input  logic            clr_overrun,
  inout  wire [XLEN-1:0]  data,
  output logic            iint,
  output logic [1:0]      pending,
  output logic [1:0]      overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state_q, state_nxt;
  logic       grant_q, grant_nxt;     // 0 = source A, 1 = source B
  logic       grant_live;
  logic [1:0] irq_s;
  logic [1:0] hist_q;
  logic [1:0] arm_cnt_q;
  logic       armed;
  logic [1:0] edge_det;
  logic [1:0] clr;
  logic [1:0] pending_nxt;
  logic [1:0] overrun_nxt;
  logic       ack_strobe;
  logic [2:0] ack_vec;
  logic [7:0] ack_byte;

`ifdef INT_SCHEDULER_SYNC_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {irq_b, irq_a};
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
  assign irq_s = {irq_b, irq_a};
`endif

  // Edge detection stays disarmed until the history register holds a real
  // sample of the (synchronized) input. A request that is already high at
  // reset release therefore never looks like a fresh edge.
  assign armed = (arm_cnt_q == ARM_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt_q <= 2'd0;
      hist_q    <= 2'b00;
    end else begin
      if (!armed) arm_cnt_q <= arm_cnt_q + 2'd1;
      hist_q <= irq_s;
    end
  end

  assign edge_det   = irq_s & ~hist_q & {2{armed}};
  assign ack_strobe = inta & dbin;
  // Fixed priority, A over B.
  assign grant_live = pending[0] ? 1'b0 : pending[1];

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    clr       = 2'b00;
    case (state_q)
      IDLE: begin
        if (|pending) state_nxt = REQ;
      end
      REQ: begin
        grant_nxt = grant_live;           // tracks live grant; frozen once in ACK
        if (ack_strobe) begin
          state_nxt = ACK;
          clr       = grant_live ? 2'b10 : 2'b01;
        end
      end
      ACK: begin
        if (!inta) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A new edge beats a same-cycle clear and is not an overrun. clr_overrun
    // loses to an overrun event in the same cycle.
    pending_nxt = edge_det | (pending & ~clr);
    overrun_nxt = (edge_det & pending & ~clr) | (overrun & {2{~clr_overrun}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      pending <= 2'b00;
      overrun <= 2'b00;
      iint    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      iint    <= int_en & (state_nxt == REQ);
    end
  end

  // RST opcode: 11_vvv_111. In IDLE the acknowledge is spurious and answers RST 7.
  assign ack_vec = (state_q == ACK) ? (grant_q    ? VEC_B : VEC_A)
                                    : (grant_live ? VEC_B : VEC_A);

  always_comb begin
    ack_byte = 8'hFF;
    if (state_q == REQ || state_q == ACK) ack_byte = {2'b11, ack_vec, 3'b111};
  end

  // rst_n gates the drive so that the bus is released as soon as reset asserts.
  assign data = (ack_strobe && rst_n) ? XLEN'(ack_byte) : {XLEN{1'bz}};

endmodule
